ysyx_25060170_ctrl: RTL and testbench

Multi-cycle sequencer for the single-issue core. It steps each instruction through fetch, decode, execute, optional memory and write-back. It drives the IFU and LSU request handshakes and gates the register-file and PC write enables from the decode control signals. It also halts on `ebreak`, flags stalled handshakes and keeps cycle and retired-instruction counters.

---
 rtl/ysyx_25060170_ctrl.sv | 128 ++++++++++++
 tb/tb_ysyx_25060170_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH, DECODE, EXEC,
// optional MEM and WB, and drives the IFU/LSU handshakes and RF/PC enables.
// Ports: clk, rst (sync, active-low); ifu_valid_i, lsu_done_i handshakes in;
//        opcode_i, MemWr_i, regS_i, RegW_i decode controls in;
//        ifu_req_o, inst_we_o, lsu_req_o, lsu_wen_o, rf_we_o, pc_we_o out;
//        stage_o state, halt_o, err_o status; cycle_cnt_o, instret_o counters.
module ysyx_25060170_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_valid_i,
    input  logic             lsu_done_i,
    input  logic [6:0]       opcode_i,
    input  logic             MemWr_i,
    input  logic [1:0]       regS_i,
    input  logic             RegW_i,
    output logic             ifu_req_o,
    output logic             inst_we_o,
    output logic             lsu_req_o,
    output logic             lsu_wen_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic [2:0]       stage_o,
    output logic             halt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

    state_t      state;
    state_t      next;
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        enter_wait;

    // A handshake state is "waiting" when its completing input is low.
    assign waiting = (state == S_FETCH && !ifu_valid_i) ||
                     (state == S_MEM   && !lsu_done_i);

    assign enter_wait = (next != state) &&
                        (next == S_FETCH || next == S_MEM);

    always_comb begin
        next      = state;
        ifu_req_o = 1'b0;
        inst_we_o = 1'b0;
        lsu_req_o = 1'b0;
        lsu_wen_o = 1'b0;
        rf_we_o   = 1'b0;
        pc_we_o   = 1'b0;
        halt_o    = 1'b0;
        err_o     = 1'b0;
        unique case (state)
            S_IDLE: next = S_FETCH;
            S_FETCH: begin
                ifu_req_o = 1'b1;
                // A same-cycle valid beats the timeout.
                if (ifu_valid_i) begin
                    inst_we_o = 1'b1;
                    next      = S_DECODE;
                end else if (wait_cnt == TO_LIMIT) begin
                    next = S_ERR;
                end
            end
            S_DECODE: begin
                if (opcode_i == OP_SYSTEM) next = S_HALT;
                else                       next = S_EXEC;
            end
            S_EXEC: begin
                if (MemWr_i || regS_i == 2'd1) next = S_MEM;
                else                           next = S_WB;
            end
            S_MEM: begin
                lsu_req_o = 1'b1;
                lsu_wen_o = MemWr_i;
                if (lsu_done_i) begin
                    next = S_WB;
                end else if (wait_cnt == TO_LIMIT) begin
                    next = S_ERR;
                end
            end
            S_WB: begin
                pc_we_o = 1'b1;
                rf_we_o = RegW_i;
                next    = S_FETCH;
            end
            S_HALT: halt_o = 1'b1;
            S_ERR:  err_o  = 1'b1;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cycle_cnt_o <= '0;
            instret_o   <= '0;
        end else begin
            state <= next;
            if (enter_wait)   wait_cnt <= '0;
            else if (waiting) wait_cnt <= wait_cnt + 16'd1;
            if (state != S_HALT && state != S_ERR)
                cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (state == S_WB)
                instret_o <= instret_o + CNT_W'(1);
        end
    end

    assign stage_o = state;

endmodule

// File: tb/tb_ysyx_25060170_ctrl.sv
// Bench for ysyx_25060170_ctrl: schedules whole instructions (fetch waits,
// mem waits, kind) and checks each cycle's outputs and counters.
module tb_ysyx_25060170_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ifu_valid_i = 1'b0;
    logic             lsu_done_i = 1'b0;
    logic [6:0]       opcode_i = 7'h13;
    logic             MemWr_i = 1'b0;
    logic [1:0]       regS_i = 2'd0;
    logic             RegW_i = 1'b0;
    logic             ifu_req_o, inst_we_o, lsu_req_o, lsu_wen_o;
    logic             rf_we_o, pc_we_o, halt_o, err_o;
    logic [2:0]       stage_o;
    logic [CNT_W-1:0] cycle_cnt_o, instret_o;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int ret    = 0;

    always #5 clk = ~clk;

    ysyx_25060170_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid_i(ifu_valid_i), .lsu_done_i(lsu_done_i),
        .opcode_i(opcode_i), .MemWr_i(MemWr_i),
        .regS_i(regS_i), .RegW_i(RegW_i),
        .ifu_req_o(ifu_req_o), .inst_we_o(inst_we_o),
        .lsu_req_o(lsu_req_o), .lsu_wen_o(lsu_wen_o),
        .rf_we_o(rf_we_o), .pc_we_o(pc_we_o),
        .stage_o(stage_o), .halt_o(halt_o), .err_o(err_o),
        .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle in which the DUT is expected to be in state st.
    // Control bits: ifu_req,inst_we,lsu_req,lsu_wen,rf_we,pc_we,halt,err
    task automatic cycle(input logic [2:0] st);
        logic [7:0] e;
        e = '0;
        case (st)
            3'd1: begin e[7] = 1'b1; e[6] = ifu_valid_i; end
            3'd4: begin e[5] = 1'b1; e[4] = MemWr_i; end
            3'd5: begin e[3] = RegW_i; e[2] = 1'b1; end
            3'd6: e[1] = 1'b1;
            3'd7: e[0] = 1'b1;
            default: e = '0;
        endcase
        @(negedge clk);
        chk($sformatf("stage@%0d", cyc), 64'(stage_o), 64'(st));
        chk($sformatf("ctl@%0d st%0d", cyc, st),
            64'({ifu_req_o, inst_we_o, lsu_req_o, lsu_wen_o,
                 rf_we_o, pc_we_o, halt_o, err_o}), 64'(e));
        chk("cycle_cnt", 64'(cycle_cnt_o), 64'(cyc));
        chk("instret", 64'(instret_o), 64'(ret));
        if (st < 3'd6) cyc++;
        if (st == 3'd5) ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        ifu_valid_i = 1'($urandom);
        lsu_done_i  = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        ret = 0;
        noise();
        cycle(3'd0);
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 ebreak.
    // fw/mw: wait cycles before ifu_valid / lsu_done.
    task automatic run_instr(input int kind, input int fw, input int mw);
        int v;
        v = int'($urandom_range(0, 2));
        case (kind)
            0: begin
                opcode_i = 7'h13; MemWr_i = 1'b0;
                regS_i = (v == 0) ? 2'd0 : 2'(v + 1);
                RegW_i = 1'($urandom);
            end
            1: begin opcode_i = 7'h03; MemWr_i = 1'b0;
                     regS_i = 2'd1; RegW_i = 1'b1; end
            2: begin opcode_i = 7'h23; MemWr_i = 1'b1;
                     regS_i = 2'd0; RegW_i = 1'b0; end
            default: begin opcode_i = 7'h73; MemWr_i = 1'b0;
                           regS_i = 2'd0; RegW_i = 1'b0; end
        endcase
        for (int i = 0; i <= fw; i++) begin
            lsu_done_i  = 1'($urandom);
            ifu_valid_i = (i == fw);
            cycle(3'd1);
        end
        noise();
        cycle(3'd2);
        if (kind == 3) begin
            for (int i = 0; i < 3; i++) begin
                noise();
                cycle(3'd6);
            end
            return;
        end
        noise();
        cycle(3'd3);
        if (kind == 1 || kind == 2) begin
            for (int i = 0; i <= mw; i++) begin
                ifu_valid_i = 1'($urandom);
                lsu_done_i  = (i == mw);
                cycle(3'd4);
            end
        end
        noise();
        cycle(3'd5);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Three addi back-to-back; the 4th FETCH sees cycle_cnt 13.
        for (int i = 0; i < 3; i++) begin
            run_instr(0, 0, 0);
            RegW_i = 1'b1;
        end
        run_instr(1, 0, 3);
        run_instr(2, 1, 2);
        run_instr(3, 0, 0);

        // Timeout: no valid for 5 FETCH cycles leads to ERR.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ifu_valid_i = 1'b0;
            cycle(3'd1);
        end
        for (int i = 0; i < 3; i++) begin
            noise();
            cycle(3'd7);
        end

        // Valid on the last allowed cycle, and a mem op at the limit.
        do_reset();
        run_instr(0, 4, 0);
        run_instr(1, 0, 4);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)));
        end
        run_instr(3, int'($urandom_range(0, 4)), 0);

        // Reset while in MEM aborts the load.
        do_reset();
        run_instr(0, 0, 0);
        opcode_i = 7'h03; MemWr_i = 1'b0; regS_i = 2'd1; RegW_i = 1'b1;
        ifu_valid_i = 1'b1;
        cycle(3'd1);
        cycle(3'd2);
        cycle(3'd3);
        lsu_done_i = 1'b0;
        cycle(3'd4);
        cycle(3'd4);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_pc_we", 64'(pc_we_o), 64'd0);
        chk("rst_mem_rf_we", 64'(rf_we_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        ret = 0;
        cycle(3'd0);
        run_instr(0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
